mfp_als_spi_responder: RTL and testbench

Synthesizable SPI responder that emulates the ambient light sensor ADC (3 leading zeros, 8 data bits MSB first, trailing zeros) seen by the MIPSfpga system's SPI master on SPI_CS/SPI_SCK/SPI_SDO. Lets the light-sensor demo and its SPI master run in simulation or on a second board with no physical sensor attached. Sits between a sample source (switches, counter, testbench) and the master's pins. All pin inputs are asynchronous to SI_ClkIn and are oversampled.

---
 rtl/mfp_als_spi_responder.sv | 170 +++++++++++++++++
 tb/tb_mfp_als_spi_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mfp_als_spi_responder.sv
// SPI responder emulating the ambient light sensor ADC: serves an 8-bit
// sample framed by leading and trailing zeros to an SPI master. CS and SCK
// are oversampled on SI_ClkIn.
module mfp_als_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BITS  = 16,
  parameter int         LEAD_ZEROS  = 3,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic        SI_ClkIn,
  input  logic        SI_Reset,
  input  logic [7:0]  sample_value,
  input  logic        sample_valid,
  input  logic        SPI_CS,
  input  logic        SPI_SCK,
  output logic        SPI_SDO,
  output logic        SPI_SDO_OE,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;

  // Places the sample after LEAD_ZEROS zeros, zero-filling the remainder.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] value);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[FRAME_BITS-1-LEAD_ZEROS -: 8] = value;
    return w;
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s;
  logic                   cs_fall, cs_rise, sck_fall;

  state_t                 state_q, state_d;
  logic [7:0]             hold_q, hold_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [FRAME_BITS-1:0]  load_w;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sdo_q, sdo_d;
  logic                   oe_q, oe_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [15:0]            count_q, count_d;

  // Synchronizer shift paths; idle level of both pins is high.
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    cs_fall    = cs_prev_q & ~cs_s;
    cs_rise    = ~cs_prev_q & cs_s;
    sck_fall   = sck_prev_q & ~sck_s;
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '1;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  // Frame FSM: next state, shift register, counters and registered outputs.
  always_comb begin
    hold_d  = sample_valid ? sample_value : hold_q;
    load_w  = frame_word(hold_d);
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        oe_d  = 1'b0;
        if (cs_fall) begin
          shift_d = load_w;
          cnt_d   = '0;
          oe_d    = 1'b1;
          sdo_d   = load_w[FRAME_BITS-1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A deselect in the same cycle as an SCK fall aborts without shifting.
        if (cs_rise) begin
          abort_d = 1'b1;
          oe_d    = 1'b0;
          sdo_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (sck_fall) begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 1'b1;
          sdo_d   = shift_q[FRAME_BITS-2];
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
            sdo_d   = 1'b0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        sdo_d = 1'b0;
        oe_d  = 1'b1;
        if (cs_rise) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sdo_d   = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      state_q <= ST_IDLE;
      hold_q  <= RESET_VALUE;
      shift_q <= '0;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      count_q <= count_d;
    end
  end

  assign SPI_SDO     = sdo_q;
  assign SPI_SDO_OE  = oe_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_mfp_als_spi_responder.sv
// Directed bench for mfp_als_spi_responder: acts as the SPI master, samples
// SDO during each SCK high phase just before the fall, and compares against
// hand-computed frame words.
module tb_mfp_als_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sample_value;
  logic        sample_valid;
  logic        cs, sck;
  logic        sdo, sdo_oe, busy, frame_done, frame_abort;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  mfp_als_spi_responder dut (
    .SI_ClkIn     (clk),
    .SI_Reset     (rst),
    .sample_value (sample_value),
    .sample_valid (sample_valid),
    .SPI_CS       (cs),
    .SPI_SCK      (sck),
    .SPI_SDO      (sdo),
    .SPI_SDO_OE   (sdo_oe),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Count pulse cycles of the completion strobes.
  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // SCK = clk/10; SDO captured while SCK is high, before each fall.
  task automatic clock_bits(input int n, output logic [31:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      word = {word[30:0], sdo};
      sck = 1'b0;
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int n, output logic [31:0] word);
    cs = 1'b0;
    repeat (10) @(negedge clk);
    clock_bits(n, word);
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic load_sample(input logic [7:0] v);
    sample_value = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_value = 8'h00;
  endtask

  logic [31:0] w;
  int d0, a0;
  logic [15:0] c0;
  bit seen;

  initial begin
    rst = 1'b1;
    cs = 1'b1;
    sck = 1'b1;
    sample_value = 8'h00;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_oe", 32'(sdo_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame with 8'hA5.
    load_sample(8'hA5);
    d0 = done_cnt;
    run_frame(16, w);
    chk("a5_word", {16'd0, w[15:0]}, 32'h14A0);
    chk("a5_done_once", 32'(done_cnt - d0), 32'd1);
    chk("a5_count", 32'(frame_count), 32'd1);
    chk("idle_oe", 32'(sdo_oe), 32'd0);

    // Aborted frame after 6 SCK falls.
    d0 = done_cnt;
    a0 = abort_cnt;
    cs = 1'b0;
    repeat (10) @(negedge clk);
    clock_bits(6, w);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_oe_on", 32'(sdo_oe), 32'd1);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_oe_off", 32'(sdo_oe), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_count", 32'(frame_count), 32'd1);
    run_frame(16, w);
    chk("after_abort_word", {16'd0, w[15:0]}, 32'h14A0);
    chk("after_abort_count", 32'(frame_count), 32'd2);

    // sample_valid coinciding with the cs_fall strobe bypasses the holding value.
    load_sample(8'hFF);
    cs = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.cs_fall) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bypass_strobe_seen", 32'(seen), 32'd1);
    load_sample(8'h3C);
    repeat (8) @(negedge clk);
    clock_bits(16, w);
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    chk("bypass_word", {16'd0, w[15:0]}, 32'h0780);
    chk("bypass_hold", 32'(dut.hold_q), 32'h3C);
    run_frame(16, w);
    chk("hold_reuse_word", {16'd0, w[15:0]}, 32'h0780);
    chk("bypass_count", 32'(frame_count), 32'd4);

    // 20 SCK falls with 8'hFF: extra bits read as zero, one completion.
    load_sample(8'hFF);
    d0 = done_cnt;
    run_frame(20, w);
    chk("extra_word", {12'd0, w[19:0]}, 32'h1FE00);
    chk("extra_done_once", 32'(done_cnt - d0), 32'd1);
    chk("extra_count", 32'(frame_count), 32'd5);

    // Asynchronous reset in the middle of a shifting frame.
    d0 = done_cnt;
    cs = 1'b0;
    repeat (10) @(negedge clk);
    clock_bits(5, w);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_sdo", 32'(sdo), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sdo", 32'(sdo), 32'd0);
    chk("arst_oe", 32'(sdo_oe), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(frame_count), 32'd0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);

    // Counter wrap from 16'hFFFF.
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    c0 = frame_count;
    chk("preload_count", 32'(c0), 32'hFFFF);
    load_sample(8'h81);
    run_frame(16, w);
    chk("wrap_word", {16'd0, w[15:0]}, 32'h1020);
    chk("wrap_count", 32'(frame_count), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
